// File: rtl/io_map_pkg.sv
// Shared definitions for the memory-mapped I/O block: address map, register
// widths, CTRL status layout and the helpers that update and read it back.
package io_map_pkg;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0014;
    localparam logic [31:0] ADDR_SDATA = 32'hF000_0020;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0024;
    localparam logic [31:0] ADDR_TCNT  = 32'hF000_0100;
    localparam logic [31:0] ADDR_TLIM  = 32'hF000_0104;
    localparam logic [31:0] ADDR_TCTL  = 32'hF000_0108;

    localparam int unsigned HEX_W = 16;
    localparam int unsigned LED_W = 10;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned SW_W  = 10;
    localparam int unsigned TIM_W = 32;

    localparam int unsigned CTRL_READY = 0;
    localparam int unsigned CTRL_OVR   = 2;

    localparam logic [HEX_W-1:0] HEX_RST = 16'h0000;

    typedef struct packed {
        logic ovr;
        logic ready;
    } ctrl_t;

    // Software may only clear status bits; a hardware set event overrides
    // both a software clear and a read-clear in the same cycle.
    function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic wr,
                                        input logic wr_ready, input logic wr_ovr,
                                        input logic rd_clr, input logic set);
        ctrl_t nxt;
        nxt = cur;
        if (wr) begin
            nxt.ready = cur.ready & wr_ready;
            nxt.ovr   = cur.ovr & wr_ovr;
        end
        if (rd_clr) nxt.ready = 1'b0;
        if (set) begin
            nxt.ready = 1'b1;
            nxt.ovr   = nxt.ovr | cur.ready;
        end
        return nxt;
    endfunction

    // Bus view of a CTRL register; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w             = '0;
        w[CTRL_READY] = c.ready;
        w[CTRL_OVR]   = c.ovr;
        return w;
    endfunction

endpackage

// File: rtl/sevenseg_dec.sv
// 4-bit hex digit to active-low seven-segment pattern (bit order gfedcba).
//   nib : digit value 0-F
//   seg : segment drive, 0 = lit
module sevenseg_dec (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/io_periph.sv
// Memory-mapped board I/O: synchronised keys, debounced switches with sticky
// ready/overrun status, LED and hex-display registers, interval timer.
//   clk, reset      : clock, async active-low reset
//   addr/wdata/we/re: single-cycle data bus, rdata combinational from addr
//   SW, KEY         : asynchronous board inputs (KEY active-low)
//   LEDR, HEX0..3   : LED register and active-low seven-segment outputs
module io_periph
    import io_map_pkg::*;
#(
    parameter int unsigned DBITS      = 32,
    parameter int unsigned ABITS      = 32,
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ABITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    input  logic [SW_W-1:0]  SW,
    input  logic [KEY_W-1:0] KEY,
    output logic [LED_W-1:0] LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [HEX_W-1:0] hex_q;
    logic [LED_W-1:0] led_q;
    logic [KEY_W-1:0] ksync1_q, ksync2_q, kdata_q;
    logic [SW_W-1:0]  ssync1_q, ssync2_q, scand_q, sdata_q;
    logic [DW-1:0]    deb_cnt_q;
    logic [PW-1:0]    presc_q;
    logic [TIM_W-1:0] tcnt_q, tlim_q, tcnt_d;
    ctrl_t            kctrl_q, sctrl_q, tctl_q, kctrl_d, sctrl_d, tctl_d;
    logic             kchg, sdiff, deb_done, sload, tick, tmatch;

    // Address-map write decode
    logic wr_hex, wr_led, wr_kctrl, wr_sctrl, wr_tcnt, wr_tlim, wr_tctl;
    assign wr_hex   = we && (addr == ABITS'(ADDR_HEX));
    assign wr_led   = we && (addr == ABITS'(ADDR_LEDR));
    assign wr_kctrl = we && (addr == ABITS'(ADDR_KCTRL));
    assign wr_sctrl = we && (addr == ABITS'(ADDR_SCTRL));
    assign wr_tcnt  = we && (addr == ABITS'(ADDR_TCNT));
    assign wr_tlim  = we && (addr == ABITS'(ADDR_TLIM));
    assign wr_tctl  = we && (addr == ABITS'(ADDR_TCTL));

    // Status, debounce and timer next-state
    always_comb begin
        kchg     = (~ksync2_q) != kdata_q;
        sdiff    = ssync2_q != scand_q;
        deb_done = deb_cnt_q == DW'(DEB_CYCLES - 1);
        sload    = !sdiff && deb_done && (scand_q != sdata_q);
        tick     = presc_q == PW'(TICK_DIV - 1);
        tmatch   = (tlim_q != '0) && (tcnt_q == tlim_q - TIM_W'(1));

        kctrl_d = ctrl_next(kctrl_q, wr_kctrl, wdata[CTRL_READY], wdata[CTRL_OVR],
                            re && (addr == ABITS'(ADDR_KDATA)), kchg);
        sctrl_d = ctrl_next(sctrl_q, wr_sctrl, wdata[CTRL_READY], wdata[CTRL_OVR],
                            re && (addr == ABITS'(ADDR_SDATA)), sload);
        tctl_d  = ctrl_next(tctl_q, wr_tctl, wdata[CTRL_READY], wdata[CTRL_OVR],
                            1'b0, tick && tmatch);

        // A bus write to TCNT overrides that cycle's tick
        tcnt_d = tcnt_q;
        if (wr_tcnt)     tcnt_d = TIM_W'(wdata);
        else if (tick)   tcnt_d = tmatch ? '0 : tcnt_q + TIM_W'(1);
    end

    // Register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_q     <= HEX_RST;
            led_q     <= '0;
            ksync1_q  <= '1;
            ksync2_q  <= '1;
            kdata_q   <= '0;
            ssync1_q  <= '0;
            ssync2_q  <= '0;
            scand_q   <= '0;
            sdata_q   <= '0;
            deb_cnt_q <= '0;
            presc_q   <= '0;
            tcnt_q    <= '0;
            tlim_q    <= '0;
            kctrl_q   <= '0;
            sctrl_q   <= '0;
            tctl_q    <= '0;
        end else begin
            if (wr_hex)  hex_q  <= wdata[HEX_W-1:0];
            if (wr_led)  led_q  <= wdata[LED_W-1:0];
            if (wr_tlim) tlim_q <= TIM_W'(wdata);

            ksync1_q <= KEY;
            ksync2_q <= ksync1_q;
            kdata_q  <= ~ksync2_q;

            ssync1_q <= SW;
            ssync2_q <= ssync1_q;
            // Candidate reloads on any difference; counter saturates once stable
            if (sdiff) begin
                scand_q   <= ssync2_q;
                deb_cnt_q <= '0;
            end else if (!deb_done) begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
            if (sload) sdata_q <= scand_q;

            presc_q <= tick ? '0 : presc_q + PW'(1);
            tcnt_q  <= tcnt_d;

            kctrl_q <= kctrl_d;
            sctrl_q <= sctrl_d;
            tctl_q  <= tctl_d;
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        case (addr)
            ABITS'(ADDR_HEX):   rdata = DBITS'(hex_q);
            ABITS'(ADDR_LEDR):  rdata = DBITS'(led_q);
            ABITS'(ADDR_KDATA): rdata = DBITS'(kdata_q);
            ABITS'(ADDR_KCTRL): rdata = DBITS'(ctrl_word(kctrl_q));
            ABITS'(ADDR_SDATA): rdata = DBITS'(sdata_q);
            ABITS'(ADDR_SCTRL): rdata = DBITS'(ctrl_word(sctrl_q));
            ABITS'(ADDR_TCNT):  rdata = DBITS'(tcnt_q);
            ABITS'(ADDR_TLIM):  rdata = DBITS'(tlim_q);
            ABITS'(ADDR_TCTL):  rdata = DBITS'(ctrl_word(tctl_q));
            default:            rdata = '0;
        endcase
    end

    assign LEDR = led_q;

    sevenseg_dec u_hex0 (.nib(hex_q[3:0]),   .seg(HEX0));
    sevenseg_dec u_hex1 (.nib(hex_q[7:4]),   .seg(HEX1));
    sevenseg_dec u_hex2 (.nib(hex_q[11:8]),  .seg(HEX2));
    sevenseg_dec u_hex3 (.nib(hex_q[15:12]), .seg(HEX3));

endmodule

// File: doc/io_periph.md
Name: io_periph

Overview:
- Memory-mapped I/O peripheral block on the data-memory bus of the single-cycle processor.
- Sits directly downstream of the processor's load/store path and owns the board I/O: SW, KEY, LEDR and HEX0-HEX3.
- Provides synchronised, debounced switch and key inputs with sticky ready/overrun status, LED and hex-display output registers, and a millisecond interval timer.
- The processor issues single-cycle reads and writes; this block returns read data combinationally in the same cycle.

Parameters:
- DBITS, 32: bus data width.
- ABITS, 32: bus address width.
- TICK_DIV, 10000: clk cycles per timer tick. 1 ms at 10 MHz.
- DEB_CYCLES, 100000: cycles SW must be stable before SDATA updates.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ABITS  bus address, word aligned.
- wdata  in  DBITS  bus write data.
- we  in  1  write strobe, sampled at rising clk.
- re  in  1  read strobe; read side effects happen at rising clk.
- rdata  out  DBITS  read data, combinational from addr.
- SW  in  10  board switches, asynchronous.
- KEY  in  4  board keys, asynchronous, active-low (pressed = 0).
- LEDR  out  10  LED register.
- HEX0..HEX3  out  7 each  seven-segment outputs, active-low segments.

Behaviour:
- Reset values: LEDR = 0; HEX register = 16'h0000, so each HEXn = 7'b1000000 ("0"); KDATA = 0; SDATA = 0; all CTRL bits = 0; TCNT = 0; TLIM = 0; prescaler = 0.
- Reset asserted mid-operation clears everything immediately.
- Address map (byte addresses):
  - F0000000 HEX, RW, 16 bits.
  - F0000004 LEDR, RW, 10 bits.
  - F0000010 KDATA, RO.
  - F0000014 KCTRL, RW.
  - F0000020 SDATA, RO.
  - F0000024 SCTRL, RW.
  - F0000100 TCNT, RW.
  - F0000104 TLIM, RW.
  - F0000108 TCTL, RW.
  - Any other address: rdata = 0; writes ignored.
- Register write width: writes take the low bits of wdata; read-back is zero-extended.
- HEX: nibble i drives HEXi through the decoder for 0-F. Register write to display change: one cycle.
- CTRL layout (KCTRL, SCTRL, TCTL):
  - bit0 ready, bit2 overrun; all other bits read 0.
  - Software can only clear these bits: writing 0 to a bit clears it, writing 1 has no effect.
- KEY path:
  - 2-flop synchroniser, then KDATA = ~KEY_sync.
  - When KDATA changes value: set ready; if ready was already 1, also set overrun.
  - re to KDATA clears ready at that clk edge.
  - Change and read in the same cycle: set wins, ready stays 1. Overrun is set only if ready was 1 before that cycle.
- SW path:
  - 2-flop synchroniser, then a debounce counter that reloads whenever the synced value differs from the candidate value.
  - When the counter reaches DEB_CYCLES-1 with the candidate stable, SDATA loads the candidate. Same ready/overrun rules as KEY; reading SDATA clears ready.
  - A bounce shorter than DEB_CYCLES produces no SDATA update.
- Timer:
  - The prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick on the wrap.
  - On a tick:
    - TLIM == 0: TCNT increments freely, wrapping 2^32-1 to 0, and no status is set.
    - TLIM != 0 and TCNT == TLIM-1: TCNT becomes 0, ready is set, and overrun is set if ready was already 1.
    - Otherwise TCNT increments.
  - A bus write to TCNT in the same cycle as a tick: the write wins and that tick's increment is dropped. The prescaler is unaffected.
  - A write to TLIM leaves TCNT unchanged. If TCNT >= the new TLIM, TCNT counts up through 2^32 wrap before it can match.
- Simultaneous write to any CTRL register and a hardware set event in the same cycle: the hardware set wins for bit0 and bit2.

Decomposition:
- io_map_pkg: address constants, CTRL bit indices, HEX reset pattern.
- Sub-module sevenseg_dec: combinational 4-bit to 7-segment active-low decoder, instantiated four times.
- Timer and debounce logic stay inline.

Test Plan:
- Reset then release; no bus activity → LEDR = 0, HEX0..3 = 7'b1000000, read of F0000108 returns 0.
- Write 16'h1A2F to F0000000 → HEX3 = "1" (7'b1111001), HEX2 = "A", HEX1 = "2", HEX0 = "F", next cycle. Write 10'h3FF to F0000004 → LEDR = 3FF. Both read back.
- Drop KEY[0] to 0 → within 3 cycles KDATA = 1 and KCTRL = 1. Release with no read → KCTRL = 5. Read KDATA, then write 0 to KCTRL → KCTRL = 0.
- TICK_DIV = 4, TLIM = 3 → TCNT sequence 0,1,2,0 with one increment every 4 clks; TCTL = 1 after first wrap, 5 after second; write TCNT = 7 on a tick cycle → TCNT = 7.
- DEB_CYCLES = 8: toggle SW[3] for 5 cycles → SDATA stays 0. Hold for 8+ cycles → SDATA = 8, SCTRL = 1.
- Assert reset mid-count with TCNT = 2 and KCTRL = 5 → all registers return to reset values asynchronously, before the next clk edge.
